// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe shared types
// ImmSrc encodings and buffer state enumeration
package imm_gen_pipe_pkg;

    typedef logic [2:0] imm_src_t;

    localparam imm_src_t IMM_I = 3'd0;
    localparam imm_src_t IMM_S = 3'd1;
    localparam imm_src_t IMM_B = 3'd2;
    localparam imm_src_t IMM_U = 3'd3;
    localparam imm_src_t IMM_J = 3'd4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe bus bundle
// producer/consumer handshake plus immediate result
interface imm_gen_pipe_if
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) ();

    logic [31:0]      Instr_in;
    imm_src_t         ImmSrc;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  Imm_Ext_out;
    logic             imm_illegal;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output Instr_in, ImmSrc, in_valid, out_ready,
        input  in_ready, Imm_Ext_out, imm_illegal,
        input  out_valid, illegal_cnt
    );

    modport slave (
        input  Instr_in, ImmSrc, in_valid, out_ready,
        output in_ready, Imm_Ext_out, imm_illegal,
        output out_valid, illegal_cnt
    );

endinterface

// File: rtl/imm_decode.sv
// imm_decode: RISC-V immediate format decode
// builds the 32-bit immediate then sign-extends to XLEN
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     Instr_in,
    input  imm_src_t        ImmSrc,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [31:0] imm32;

    // Select the format; illegal selects yield zero
    always_comb begin
        imm32     = '0;
        illegal_o = 1'b0;
        unique case (ImmSrc)
            IMM_I: imm32 = {{20{Instr_in[31]}}, Instr_in[31:20]};
            IMM_S: imm32 = {{20{Instr_in[31]}}, Instr_in[31:25],
                            Instr_in[11:7]};
            IMM_B: imm32 = {{19{Instr_in[31]}}, Instr_in[31],
                            Instr_in[7], Instr_in[30:25],
                            Instr_in[11:8], 1'b0};
            IMM_U: imm32 = {Instr_in[31:12], 12'b0};
            IMM_J: imm32 = {{11{Instr_in[31]}}, Instr_in[31],
                            Instr_in[19:12], Instr_in[20],
                            Instr_in[30:21], 1'b0};
            default: illegal_o = 1'b1;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator
// decode feeds a 2-entry skid buffer with illegal counter
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Instr_in,
    input  imm_src_t         ImmSrc,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [XLEN-1:0]  Imm_Ext_out,
    output logic             imm_illegal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;

    buf_state_t       state_q, state_d;
    logic [XLEN-1:0]  head_imm_q, head_imm_d;
    logic             head_ill_q, head_ill_d;
    logic [XLEN-1:0]  tail_imm_q, tail_imm_d;
    logic             tail_ill_q, tail_ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d;

    logic             in_fire;
    logic             out_fire;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .Instr_in  (Instr_in),
        .ImmSrc    (ImmSrc),
        .imm_o     (dec_imm),
        .illegal_o (dec_ill)
    );

    assign in_fire  = in_valid && rdy_q;
    assign out_fire = out_ready && (state_q != ST_EMPTY);

    // Buffer occupancy and entry movement
    always_comb begin
        state_d    = state_q;
        head_imm_d = head_imm_q;
        head_ill_d = head_ill_q;
        tail_imm_d = tail_imm_q;
        tail_ill_d = tail_ill_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    head_imm_d = dec_imm;
                    head_ill_d = dec_ill;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    head_imm_d = dec_imm;
                    head_ill_d = dec_ill;
                end else if (in_fire) begin
                    tail_imm_d = dec_imm;
                    tail_ill_d = dec_ill;
                    state_d    = ST_FULL;
                end else if (out_fire) begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    head_imm_d = tail_imm_q;
                    head_ill_d = tail_ill_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Ready is a flop so out_ready never reaches in_ready
    always_comb begin
        rdy_d = (state_d != ST_FULL);
    end

    // Saturating count of accepted illegal formats
    always_comb begin
        cnt_d = cnt_q;
        if (in_fire && dec_ill && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            head_imm_q <= '0;
            head_ill_q <= 1'b0;
            tail_imm_q <= '0;
            tail_ill_q <= 1'b0;
            cnt_q      <= '0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_imm_q <= head_imm_d;
            head_ill_q <= head_ill_d;
            tail_imm_q <= tail_imm_d;
            tail_ill_q <= tail_ill_d;
            cnt_q      <= cnt_d;
            rdy_q      <= rdy_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign Imm_Ext_out = head_imm_q;
    assign imm_illegal = head_ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table vectors, corner sequences, random
// two DUTs (XLEN=32/CNT_W=8 and XLEN=64/CNT_W=2) share stimulus
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .CNT_W(8)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .CNT_W(2)) b64 ();

    logic [31:0] d_instr;
    logic [2:0]  d_src;
    logic        d_iv;
    logic        d_ordy;

    assign b32.Instr_in  = d_instr;
    assign b32.ImmSrc    = d_src;
    assign b32.in_valid  = d_iv;
    assign b32.out_ready = d_ordy;
    assign b64.Instr_in  = d_instr;
    assign b64.ImmSrc    = d_src;
    assign b64.in_valid  = d_iv;
    assign b64.out_ready = d_ordy;

    imm_gen_pipe #(.XLEN(32), .CNT_W(8)) u_dut32 (
        .clk         (clk),
        .rst         (rst),
        .Instr_in    (b32.Instr_in),
        .ImmSrc      (b32.ImmSrc),
        .in_valid    (b32.in_valid),
        .in_ready    (b32.in_ready),
        .Imm_Ext_out (b32.Imm_Ext_out),
        .imm_illegal (b32.imm_illegal),
        .out_valid   (b32.out_valid),
        .out_ready   (b32.out_ready),
        .illegal_cnt (b32.illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u_dut64 (
        .clk         (clk),
        .rst         (rst),
        .Instr_in    (b64.Instr_in),
        .ImmSrc      (b64.ImmSrc),
        .in_valid    (b64.in_valid),
        .in_ready    (b64.in_ready),
        .Imm_Ext_out (b64.Imm_Ext_out),
        .imm_illegal (b64.imm_illegal),
        .out_valid   (b64.out_valid),
        .out_ready   (b64.out_ready),
        .illegal_cnt (b64.illegal_cnt)
    );

    typedef struct {
        logic [63:0] imm;
        logic        ill;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [63:0] exp;
        logic        ill;
    } vec_t;

    ent_t        q[$];
    int unsigned m_cnt8;
    int unsigned m_cnt2;
    int          total;
    int          passed;
    vec_t        tv[11];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Immediate value from the format rules, using arithmetic
    function automatic logic [63:0] ref_imm(input logic [31:0] ins,
                                            input logic [2:0] src);
        longint s;
        longint hi;
        longint r;
        s  = longint'($signed(ins));
        hi = s >>> 31;
        r  = 0;
        case (src)
            3'd0: r = s >>> 20;
            3'd1: begin
                r = (s >>> 25) * 32;
                r = r + longint'(ins[11:7]);
            end
            3'd2: begin
                r = hi * 4096;
                r = r + longint'(ins[7]) * 2048;
                r = r + longint'(ins[30:25]) * 32;
                r = r + longint'(ins[11:8]) * 2;
            end
            3'd3: r = (s >>> 12) * 4096;
            3'd4: begin
                r = hi * 1048576;
                r = r + longint'(ins[19:12]) * 4096;
                r = r + longint'(ins[20]) * 2048;
                r = r + longint'(ins[30:21]) * 2;
            end
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic check_model();
        logic [63:0] e32;
        chk("in_ready32", 64'(b32.in_ready), 64'(q.size() < 2));
        chk("in_ready64", 64'(b64.in_ready), 64'(q.size() < 2));
        chk("out_valid32", 64'(b32.out_valid), 64'(q.size() > 0));
        chk("out_valid64", 64'(b64.out_valid), 64'(q.size() > 0));
        chk("cnt32", 64'(b32.illegal_cnt), 64'(m_cnt8));
        chk("cnt64", 64'(b64.illegal_cnt), 64'(m_cnt2));
        if (q.size() > 0) begin
            e32 = {32'b0, q[0].imm[31:0]};
            chk("head32", 64'(b32.Imm_Ext_out), e32);
            chk("head64", b64.Imm_Ext_out, q[0].imm);
            chk("ill32", 64'(b32.imm_illegal), 64'(q[0].ill));
            chk("ill64", 64'(b64.imm_illegal), 64'(q[0].ill));
        end
    endtask

    // One clock: advance the reference model, then compare
    task automatic tick();
        bit   inf;
        bit   outf;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else begin
            inf  = d_iv && (q.size() < 2);
            outf = d_ordy && (q.size() > 0);
            if (outf) void'(q.pop_front());
            if (inf) begin
                e.ill = (d_src >= 3'd5);
                e.imm = e.ill ? 64'd0 : ref_imm(d_instr, d_src);
                q.push_back(e);
                if (e.ill && m_cnt8 < 255) m_cnt8++;
                if (e.ill && m_cnt2 < 3) m_cnt2++;
            end
        end
        #1;
        check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ov32"}, 64'(b32.out_valid), 64'd0);
        chk({tag, "_ir32"}, 64'(b32.in_ready), 64'd1);
        chk({tag, "_imm32"}, 64'(b32.Imm_Ext_out), 64'd0);
        chk({tag, "_ill32"}, 64'(b32.imm_illegal), 64'd0);
        chk({tag, "_cnt32"}, 64'(b32.illegal_cnt), 64'd0);
        chk({tag, "_ov64"}, 64'(b64.out_valid), 64'd0);
        chk({tag, "_imm64"}, b64.Imm_Ext_out, 64'd0);
        chk({tag, "_cnt64"}, 64'(b64.illegal_cnt), 64'd0);
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        m_cnt8  = 0;
        m_cnt2  = 0;
        d_instr = '0;
        d_src   = '0;
        d_iv    = 1'b0;
        d_ordy  = 1'b0;
        rst     = 1'b1;

        tv[0]  = '{32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        tv[1]  = '{32'h7FF00013, 3'd0, 64'h00000000000007FF, 1'b0};
        tv[2]  = '{32'hFE112E23, 3'd1, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tv[3]  = '{32'h00208463, 3'd2, 64'h0000000000000008, 1'b0};
        tv[4]  = '{32'hFE208EE3, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tv[5]  = '{32'h123452B7, 3'd3, 64'h0000000012345000, 1'b0};
        tv[6]  = '{32'hFF9FF06F, 3'd4, 64'hFFFFFFFFFFFFFFF8, 1'b0};
        tv[7]  = '{32'h800002B7, 3'd3, 64'hFFFFFFFF80000000, 1'b0};
        tv[8]  = '{32'hFFFFFFFF, 3'd5, 64'h0000000000000000, 1'b1};
        tv[9]  = '{32'hFFFFFFFF, 3'd6, 64'h0000000000000000, 1'b1};
        tv[10] = '{32'hA5A5A5A5, 3'd7, 64'h0000000000000000, 1'b1};

        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        foreach (tv[i]) begin
            d_instr = tv[i].instr;
            d_src   = tv[i].src;
            d_iv    = 1'b1;
            d_ordy  = 1'b1;
            tick();
            chk($sformatf("tv%0d_ov", i), 64'(b32.out_valid), 64'd1);
            chk($sformatf("tv%0d_imm32", i), 64'(b32.Imm_Ext_out),
                {32'b0, tv[i].exp[31:0]});
            chk($sformatf("tv%0d_imm64", i), b64.Imm_Ext_out, tv[i].exp);
            chk($sformatf("tv%0d_ill", i), 64'(b32.imm_illegal),
                64'(tv[i].ill));
            d_iv = 1'b0;
            tick();
        end
        chk("cnt32_after3", 64'(b32.illegal_cnt), 64'd3);
        chk("cnt64_after3", 64'(b64.illegal_cnt), 64'd3);

        d_src = 3'd6;
        d_iv  = 1'b1;
        tick();
        tick();
        d_iv = 1'b0;
        tick();
        chk("cnt32_after5", 64'(b32.illegal_cnt), 64'd5);
        chk("cnt64_sat", 64'(b64.illegal_cnt), 64'd3);

        rst = 1'b1;
        tick();
        rst     = 1'b0;
        d_ordy  = 1'b0;
        d_src   = 3'd0;
        d_iv    = 1'b1;
        d_instr = 32'h00100013;
        tick();
        chk("bp1_ir", 64'(b32.in_ready), 64'd1);
        chk("bp1_head", 64'(b32.Imm_Ext_out), 64'd1);
        d_instr = 32'h00200013;
        tick();
        chk("bp2_ir", 64'(b32.in_ready), 64'd0);
        d_instr = 32'h00300013;
        tick();
        chk("bp3_ir", 64'(b32.in_ready), 64'd0);
        chk("bp3_hold", 64'(b32.Imm_Ext_out), 64'd1);
        tick();
        chk("bp4_hold", 64'(b32.Imm_Ext_out), 64'd1);
        d_ordy = 1'b1;
        tick();
        chk("bp5_head", 64'(b32.Imm_Ext_out), 64'd2);
        chk("bp5_ir", 64'(b32.in_ready), 64'd1);
        tick();
        chk("bp6_head", 64'(b32.Imm_Ext_out), 64'd3);
        chk("bp6_ov", 64'(b32.out_valid), 64'd1);
        d_iv = 1'b0;
        tick();
        chk("bp7_ov", 64'(b32.out_valid), 64'd0);

        d_ordy = 1'b0;
        d_src  = 3'd7;
        d_iv   = 1'b1;
        tick();
        tick();
        chk("full_ir", 64'(b32.in_ready), 64'd0);
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_full");
        rst  = 1'b0;
        d_iv = 1'b0;
        tick();

        for (int n = 0; n < 800; n++) begin
            d_instr = $urandom;
            d_src   = 3'($urandom_range(0, 7));
            d_iv    = ($urandom_range(0, 3) != 0);
            d_ordy  = ($urandom_range(0, 2) != 0);
            rst     = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst  = 1'b0;
        d_iv = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
